// File: rtl/sdram_mon_pkg.sv
// Shared types for the SDRAM command monitor: command codes, error strobe
// bit positions, the logged event record and the pin-level command decoder.
package sdram_mon_pkg;

  localparam int BA_W   = 2;
  localparam int ADDR_W = 13;
  localparam int ERR_W  = 6;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4,
    CMD_REF = 3'd5,
    CMD_MRS = 3'd6,
    CMD_BST = 3'd7
  } sdram_cmd_e;

  // Bit positions inside err_pulse.
  localparam int ERR_RW_CLOSED = 0;  // RD/WR to a bank with no open row
  localparam int ERR_ACT_OPEN  = 1;  // ACT to a bank that already has a row open
  localparam int ERR_TRCD      = 2;  // RD/WR too soon after ACT
  localparam int ERR_TRP       = 3;  // ACT too soon after PRE
  localparam int ERR_REF_OPEN  = 4;  // REF while some bank is open
  localparam int ERR_TRFC      = 5;  // any command too soon after REF

  typedef struct packed {
    sdram_cmd_e          cmd;
    logic [BA_W-1:0]     ba;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W-1:0]   row;
  } sdram_evt_t;

  // A command only exists when the clock is enabled and the chip is selected.
  function automatic sdram_cmd_e decode_cmd(input logic cke, input logic cs_n,
                                            input logic ras_n, input logic cas_n,
                                            input logic we_n);
    sdram_cmd_e c;
    c = CMD_NOP;
    if (cke && !cs_n) begin
      case ({ras_n, cas_n, we_n})
        3'b011:  c = CMD_ACT;
        3'b101:  c = CMD_RD;
        3'b100:  c = CMD_WR;
        3'b010:  c = CMD_PRE;
        3'b001:  c = CMD_REF;
        3'b000:  c = CMD_MRS;
        3'b110:  c = CMD_BST;
        default: c = CMD_NOP;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/sdram_cmd_monitor_if.sv
// Event stream from the monitor to whatever consumes the command log.
//
// Handshake: the master holds evt_valid and all evt_* fields stable until the
// beat is taken; a beat transfers on any rising clock edge where
// evt_valid=1 and evt_ready=1. evt_ready may be driven freely and does not
// depend on evt_valid.
interface sdram_cmd_monitor_if;
  import sdram_mon_pkg::*;

  logic              evt_valid;
  logic              evt_ready;
  logic [2:0]        evt_cmd;
  logic [BA_W-1:0]   evt_ba;
  logic [ADDR_W-1:0] evt_addr;
  logic [ADDR_W-1:0] evt_row;

  modport master (
    output evt_valid, evt_cmd, evt_ba, evt_addr, evt_row,
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_cmd, evt_ba, evt_addr, evt_row,
    output evt_ready
  );

endinterface

// File: rtl/sdram_mon_fifo.sv
// Synchronous event FIFO. Output data comes straight from the storage flops
// and the valid flag is its own register, so nothing combinational from the
// write side reaches the read side.
module sdram_mon_fifo
  import sdram_mon_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  sdram_evt_t push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic       rd_valid,
  output sdram_evt_t rd_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  sdram_evt_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          do_push;
  logic          do_pop;
  logic          valid_q;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign rd_valid = valid_q;
  assign rd_data  = mem[rd_ptr];

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Pointers, occupancy, valid flag and storage; reset scrubs old entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count   <= count_next;
      valid_q <= (count_next != '0);
    end
  end

endmodule

// File: rtl/sdram_cmd_monitor.sv
// Passive SDRAM command bus monitor: decodes each cycle's command, tracks
// per-bank open rows and timing, flags protocol violations, and logs every
// non-NOP command to an event stream.
module sdram_cmd_monitor
  import sdram_mon_pkg::*;
#(
  parameter int TRCD       = 3,
  parameter int TRP        = 3,
  parameter int TRFC       = 7,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    sdram_clk,
  input  logic                    sdram_rst,
  input  logic                    sdr_cke,
  input  logic                    sdr_cs_n,
  input  logic                    sdr_ras_n,
  input  logic                    sdr_cas_n,
  input  logic                    sdr_we_n,
  input  logic [BA_W-1:0]         sdr_ba,
  input  logic [ADDR_W-1:0]       sdr_addr,
  input  logic                    sdr_init_done,
  sdram_cmd_monitor_if.master     evt,
  output logic [ERR_W-1:0]        err_pulse,
  output logic [15:0]             err_count,
  output logic                    evt_overflow,
  output logic [ADDR_W-1:0]       mode_reg
);

  localparam int TMAX_A = (TRCD > TRP) ? TRCD : TRP;
  localparam int TMAX   = (TMAX_A > TRFC) ? TMAX_A : TRFC;
  localparam int CNT_W  = $clog2(TMAX + 1);
  localparam int NBANK  = 1 << BA_W;

  localparam logic [CNT_W-1:0] CNT_SAT   = '1;
  localparam logic [CNT_W-1:0] TRCD_LIM  = CNT_W'(TRCD - 1);
  localparam logic [CNT_W-1:0] TRP_LIM   = CNT_W'(TRP - 1);
  localparam logic [CNT_W-1:0] TRFC_LIM  = CNT_W'(TRFC - 1);
  localparam logic [CNT_W-1:0] TRFC_SAT  = CNT_W'(TRFC);

  sdram_cmd_e        cmd;
  logic              is_rw;
  logic [NBANK-1:0]  bank_open;
  logic [ADDR_W-1:0] bank_row [NBANK];
  logic [CNT_W-1:0]  bank_cnt [NBANK];
  logic [CNT_W-1:0]  ref_cnt;
  logic [ERR_W-1:0]  err_next;
  logic [16:0]       err_sum;

  sdram_evt_t        push_data;
  sdram_evt_t        rd_data;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_valid;

  // Decode the pins and build the event record (row is the pre-update value).
  always_comb begin
    cmd            = decode_cmd(sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n);
    is_rw          = (cmd == CMD_RD) || (cmd == CMD_WR);
    push           = (cmd != CMD_NOP);
    push_data.cmd  = cmd;
    push_data.ba   = sdr_ba;
    push_data.addr = sdr_addr;
    push_data.row  = bank_row[sdr_ba];
  end

  // Protocol checks against the bank/refresh state as it stood before this command.
  always_comb begin
    err_next = '0;
    if (sdr_init_done) begin
      if (is_rw && !bank_open[sdr_ba])                 err_next[ERR_RW_CLOSED] = 1'b1;
      if ((cmd == CMD_ACT) && bank_open[sdr_ba])       err_next[ERR_ACT_OPEN]  = 1'b1;
      if (is_rw && (bank_cnt[sdr_ba] < TRCD_LIM))      err_next[ERR_TRCD]      = 1'b1;
      if ((cmd == CMD_ACT) && (bank_cnt[sdr_ba] < TRP_LIM))
                                                       err_next[ERR_TRP]       = 1'b1;
      if ((cmd == CMD_REF) && (|bank_open))            err_next[ERR_REF_OPEN]  = 1'b1;
      if ((cmd != CMD_NOP) && (ref_cnt < TRFC_LIM))    err_next[ERR_TRFC]      = 1'b1;
    end
  end

  // Per-bank open flag, open row and cycles since the last ACT/PRE.
  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      bank_open <= '0;
      for (int b = 0; b < NBANK; b++) begin
        bank_row[b] <= '0;
        bank_cnt[b] <= CNT_SAT;
      end
    end else begin
      for (int b = 0; b < NBANK; b++) begin
        if ((cmd == CMD_ACT) && (sdr_ba == BA_W'(b))) begin
          bank_open[b] <= 1'b1;
          bank_row[b]  <= sdr_addr;
          bank_cnt[b]  <= '0;
        end else if ((cmd == CMD_PRE) && ((sdr_ba == BA_W'(b)) || sdr_addr[10])) begin
          bank_open[b] <= 1'b0;
          bank_cnt[b]  <= '0;
        end else begin
          // Auto-precharge closes the bank once the access itself was checked.
          if (is_rw && (sdr_ba == BA_W'(b)) && sdr_addr[10]) bank_open[b] <= 1'b0;
          if (bank_cnt[b] != CNT_SAT) bank_cnt[b] <= bank_cnt[b] + 1'b1;
        end
      end
    end
  end

  // Cycles since the last REF, parked at TRFC once the window has passed.
  always_ff @(posedge sdram_clk) begin
    if (sdram_rst)              ref_cnt <= TRFC_SAT;
    else if (cmd == CMD_REF)    ref_cnt <= '0;
    else if (ref_cnt < TRFC_SAT) ref_cnt <= ref_cnt + 1'b1;
  end

  assign err_sum = {1'b0, err_count} + 17'($countones(err_pulse));

  // Error strobe, saturating error total, mode register shadow, overflow flag.
  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      err_pulse    <= '0;
      err_count    <= '0;
      mode_reg     <= '0;
      evt_overflow <= 1'b0;
    end else begin
      err_pulse <= err_next;
      err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
      if (cmd == CMD_MRS) mode_reg <= sdr_addr;
      if (push && fifo_full && !pop) evt_overflow <= 1'b1;
    end
  end

  assign pop = !fifo_empty && evt.evt_ready;

  sdram_mon_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (sdram_clk),
    .rst       (sdram_rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .rd_valid  (fifo_valid),
    .rd_data   (rd_data)
  );

  assign evt.evt_valid = fifo_valid;
  assign evt.evt_cmd   = rd_data.cmd;
  assign evt.evt_ba    = rd_data.ba;
  assign evt.evt_addr  = rd_data.addr;
  assign evt.evt_row   = rd_data.row;

endmodule
